// File: rtl/ext_mem_emu.sv
// Clocked emulation of a slow external memory behind the m6809 bus: configurable
// wait states, optional writes and a big-endian reset-vector overlay at the top.
module ext_mem_emu #(
  parameter int            AW          = 4,
  parameter int            DW          = 8,
  parameter int            WAIT_STATES = 2,
  parameter int            WRITABLE    = 1,
  parameter int            VEC_EN      = 1,
  parameter logic [15:0]   RESET_VEC   = 16'hfff0,
  parameter logic [DW-1:0] FILL        = 'h12,
  parameter string         INIT_FILE   = ""
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sel,
  input  logic          we,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          ready,
  output logic          busy,
  output logic          write_err
);
  // Handshake: an access is taken on an edge where sel=1 in IDLE; sel must stay
  // high through the wait states (dropping it aborts with no ready and no write);
  // ready pulses for exactly one cycle on completion and sel is ignored then.

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
  typedef logic [DEPTH-1:0][DW-1:0] mem_t;

  // Power-up image: every location FILL.
  function automatic mem_t mem_image();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = FILL;
    return m;
  endfunction

  mem_t          mem = mem_image();
  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] a_q;
  logic          we_q;
  logic [DW-1:0] din_q;

  logic [AW-1:0] op_a;
  logic          op_we;
  logic [DW-1:0] op_din;
  logic [DW-1:0] vec_byte;
  logic [DW-1:0] rd_data;
  logic          overlay;
  logic          wr_ok;
  logic          enter_done;

  // In IDLE the live inputs are the operands (zero-wait access completes on the
  // sampling edge); afterwards only the latched copy is used.
  always_comb begin
    op_a       = (state == IDLE) ? a   : a_q;
    op_we      = (state == IDLE) ? we  : we_q;
    op_din     = (state == IDLE) ? din : din_q;
    overlay    = (VEC_EN != 0) && (op_a >= AW'(DEPTH - 2));
    vec_byte   = op_a[0] ? DW'(RESET_VEC[7:0]) : DW'(RESET_VEC[15:8]);
    rd_data    = overlay ? vec_byte : mem[op_a];
    wr_ok      = (WRITABLE != 0) && !overlay;
    enter_done = sel && (((state == IDLE) && (WAIT_STATES == 0)) ||
                         ((state == WAIT) && (cnt == 4'd0)));
  end

  // Array writes land on the same edge the FSM enters DONE; reset held on that
  // edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (rst_n && enter_done && op_we && wr_ok)
      mem[op_a] <= op_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      a_q       <= '0;
      we_q      <= 1'b0;
      din_q     <= '0;
      dout      <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      write_err <= 1'b0;
    end else begin
      ready     <= 1'b0;
      write_err <= 1'b0;
      case (state)
        IDLE: begin
          if (sel) begin
            a_q   <= a;
            we_q  <= we;
            din_q <= din;
            busy  <= 1'b1;
            if (WAIT_STATES == 0) begin
              state     <= DONE;
              ready     <= 1'b1;
              write_err <= op_we && !wr_ok;
              if (!op_we) dout <= rd_data;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (!sel) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= 4'd0;
          end else if (cnt == 4'd0) begin
            state     <= DONE;
            ready     <= 1'b1;
            write_err <= op_we && !wr_ok;
            if (!op_we) dout <= rd_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ext_mem_emu.sv
// Bench for ext_mem_emu: default, read-only and zero-wait instances checked against
// a behavioural memory model (contents, vector overlay, drop rules, latency).
module tb_ext_mem_emu;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel [3];
    logic       we [3];
    logic [3:0] a [3];
    logic [7:0] din [3];
    logic [7:0] dout [3];
    logic       ready [3];
    logic       busy [3];
    logic       write_err [3];

    int checks = 0;
    int errors = 0;

    // Reference model: per-instance contents, last read value, wait states.
    logic [7:0] model_mem [3][16];
    logic [7:0] model_dout [3];
    int         ws_of [3] = '{2, 2, 0};

    typedef struct { int k; logic w; logic [3:0] addr; logic [7:0] d; } acc_t;

    always #5 clk = ~clk;

    ext_mem_emu u0 (.clk(clk), .rst_n(rst_n), .sel(sel[0]), .we(we[0]), .a(a[0]),
        .din(din[0]), .dout(dout[0]), .ready(ready[0]), .busy(busy[0]), .write_err(write_err[0]));
    ext_mem_emu #(.WRITABLE(0)) u1 (.clk(clk), .rst_n(rst_n), .sel(sel[1]), .we(we[1]), .a(a[1]),
        .din(din[1]), .dout(dout[1]), .ready(ready[1]), .busy(busy[1]), .write_err(write_err[1]));
    ext_mem_emu #(.WAIT_STATES(0)) u2 (.clk(clk), .rst_n(rst_n), .sel(sel[2]), .we(we[2]), .a(a[2]),
        .din(din[2]), .dout(dout[2]), .ready(ready[2]), .busy(busy[2]), .write_err(write_err[2]));

    function automatic logic [7:0] model_read(input int k, input logic [3:0] addr);
        logic [15:0] vec = 16'hfff0;
        if (addr == 4'd14) return vec[15:8];
        if (addr == 4'd15) return vec[7:0];
        return model_mem[k][addr];
    endfunction

    // Applies one completed access to the model; returns the expected write_err.
    function automatic logic model_step(input int k, input logic w, input logic [3:0] addr,
                                        input logic [7:0] d);
        logic drop = w && ((k == 1) || (addr >= 4'd14));
        if (!w) model_dout[k] = model_read(k, addr);
        else if (!drop) model_mem[k][addr] = d;
        return drop;
    endfunction

    // Driver: one access with sel held until ready; operands scrambled after sampling.
    task automatic run_access(input int k, input logic w, input logic [3:0] addr, input logic [7:0] d,
                              output int lat, output logic [7:0] rd, output logic werr,
                              output int bcnt, output logic post_busy);
        bit found = 0;
        lat = 0; rd = dout[k]; werr = 1'b0; bcnt = 0;
        @(posedge clk); #1;
        sel[k] = 1'b1; we[k] = w; a[k] = addr; din[k] = d;
        @(posedge clk); #1;
        we[k] = ~w; a[k] = 4'($urandom); din[k] = 8'($urandom);
        for (int i = 1; i <= 20 && !found; i++) begin
            if (busy[k]) bcnt++;
            if (ready[k]) begin
                found = 1; lat = i; rd = dout[k]; werr = write_err[k]; sel[k] = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        sel[k] = 1'b0;
        @(posedge clk); #1;
        post_busy = busy[k];
    endtask

    task automatic test_reset();
        #12;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dout[k] !== 8'h00 || ready[k] !== 1'b0 || busy[k] !== 1'b0 || write_err[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset k=%0d: dout=%h ready=%b busy=%b werr=%b, required all 0",
                         k, dout[k], ready[k], busy[k], write_err[k]);
            end
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_vector_read();
        acc_t seq [3];
        int lat, bcnt; logic [7:0] rd; logic werr, pb, ew;
        seq[0] = '{0, 1'b0, 4'he, 8'h00};
        seq[1] = '{0, 1'b0, 4'hf, 8'h00};
        seq[2] = '{0, 1'b0, 4'h3, 8'h00};
        foreach (seq[i]) begin
            run_access(seq[i].k, seq[i].w, seq[i].addr, seq[i].d, lat, rd, werr, bcnt, pb);
            ew = model_step(seq[i].k, seq[i].w, seq[i].addr, seq[i].d);
            checks++;
            if (lat !== ws_of[seq[i].k] + 1 || bcnt !== ws_of[seq[i].k] + 1 || pb !== 1'b0) begin
                errors++;
                $display("FAIL vec_timing a=%h: lat=%0d busy=%0d post_busy=%b, required lat=busy=%0d post_busy=0",
                         seq[i].addr, lat, bcnt, pb, ws_of[seq[i].k] + 1);
            end
            checks++;
            if (rd !== model_dout[seq[i].k] || werr !== ew) begin
                errors++;
                $display("FAIL vec_data a=%h: dout=%h werr=%b, required dout=%h werr=%b",
                         seq[i].addr, rd, werr, model_dout[seq[i].k], ew);
            end
        end
    endtask

    task automatic test_write();
        acc_t seq [2];
        int lat, bcnt; logic [7:0] rd; logic werr, pb, ew;
        seq[0] = '{0, 1'b1, 4'h0, 8'h4f};
        seq[1] = '{0, 1'b0, 4'h0, 8'h00};
        foreach (seq[i]) begin
            run_access(seq[i].k, seq[i].w, seq[i].addr, seq[i].d, lat, rd, werr, bcnt, pb);
            ew = model_step(seq[i].k, seq[i].w, seq[i].addr, seq[i].d);
            checks++;
            if (lat !== 3 || bcnt !== 3 || pb !== 1'b0) begin
                errors++;
                $display("FAIL wr_timing step=%0d: lat=%0d busy=%0d post_busy=%b, required 3/3/0", i, lat, bcnt, pb);
            end
            checks++;
            if (rd !== model_dout[seq[i].k] || werr !== ew) begin
                errors++;
                $display("FAIL wr_data step=%0d: dout=%h werr=%b, required dout=%h werr=%b",
                         i, rd, werr, model_dout[seq[i].k], ew);
            end
        end
    endtask

    task automatic test_write_drop();
        acc_t seq [4];
        int lat, bcnt; logic [7:0] rd; logic werr, pb, ew;
        seq[0] = '{0, 1'b1, 4'he, 8'h00};
        seq[1] = '{0, 1'b0, 4'he, 8'h00};
        seq[2] = '{1, 1'b1, 4'h0, 8'h80 | 8'($urandom_range(0, 127))};
        seq[3] = '{1, 1'b0, 4'h0, 8'h00};
        foreach (seq[i]) begin
            run_access(seq[i].k, seq[i].w, seq[i].addr, seq[i].d, lat, rd, werr, bcnt, pb);
            ew = model_step(seq[i].k, seq[i].w, seq[i].addr, seq[i].d);
            checks++;
            if (lat !== 3) begin
                errors++;
                $display("FAIL drop_lat step=%0d: lat=%0d, required 3", i, lat);
            end
            checks++;
            if (rd !== model_dout[seq[i].k] || werr !== ew) begin
                errors++;
                $display("FAIL drop_data step=%0d: dout=%h werr=%b, required dout=%h werr=%b",
                         i, rd, werr, model_dout[seq[i].k], ew);
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] pre = model_dout[0];
        bit saw_ready = 0;
        logic b1;
        int lat, bcnt; logic [7:0] rd; logic werr, pb;
        @(posedge clk); #1;
        sel[0] = 1'b1; we[0] = 1'b1; a[0] = 4'h1; din[0] = 8'h5c;
        @(posedge clk); #1;
        sel[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ready[0]) saw_ready = 1;
            if (i == 0) b1 = busy[0];
        end
        checks++;
        if (saw_ready !== 1'b0 || b1 !== 1'b0 || dout[0] !== pre) begin
            errors++;
            $display("FAIL abort: ready_seen=%b busy=%b dout=%h, required 0/0/%h", saw_ready, b1, dout[0], pre);
        end
        run_access(0, 1'b0, 4'h1, 8'h00, lat, rd, werr, bcnt, pb);
        void'(model_step(0, 1'b0, 4'h1, 8'h00));
        checks++;
        if (rd !== model_dout[0] || lat !== 3) begin
            errors++;
            $display("FAIL abort_readback: dout=%h lat=%0d, required dout=%h lat=3", rd, lat, model_dout[0]);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt; logic [7:0] rd; logic werr, pb;
        logic [7:0] d0 = 8'($urandom);
        logic [7:0] d1 = ~d0;
        logic exp_ready;
        run_access(2, 1'b1, 4'h0, d0, lat, rd, werr, bcnt, pb);
        void'(model_step(2, 1'b1, 4'h0, d0));
        run_access(2, 1'b1, 4'h1, d1, lat, rd, werr, bcnt, pb);
        void'(model_step(2, 1'b1, 4'h1, d1));
        checks++;
        if (lat !== 1 || bcnt !== 1 || werr !== 1'b0 || pb !== 1'b0) begin
            errors++;
            $display("FAIL b2b_write: lat=%0d busy=%0d werr=%b post_busy=%b, required 1/1/0/0", lat, bcnt, werr, pb);
        end
        @(posedge clk); #1;
        sel[2] = 1'b1; we[2] = 1'b0; a[2] = 4'h0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            exp_ready = (c % 2 == 1);
            if (exp_ready) void'(model_step(2, 1'b0, 4'(((c - 1) / 2) % 2), 8'h00));
            checks++;
            if (ready[2] !== exp_ready || dout[2] !== model_dout[2]) begin
                errors++;
                $display("FAIL b2b cycle=%0d: ready=%b dout=%h, required ready=%b dout=%h",
                         c, ready[2], dout[2], exp_ready, model_dout[2]);
            end
            a[2] = 4'((c / 2) % 2);
        end
        sel[2] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        logic [7:0] d = 8'h80 | 8'($urandom_range(0, 127));
        int lat, bcnt; logic [7:0] rd; logic werr, pb;
        @(posedge clk); #1;
        sel[0] = 1'b1; we[0] = 1'b1; a[0] = 4'h2; din[0] = d;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0; sel[0] = 1'b0;
        for (int k = 0; k < 3; k++) model_dout[k] = 8'h00;
        #1;
        checks++;
        if (ready[0] !== 1'b0 || busy[0] !== 1'b0 || dout[0] !== 8'h00 || write_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ready=%b busy=%b dout=%h werr=%b, required all 0",
                     ready[0], busy[0], dout[0], write_err[0]);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        run_access(0, 1'b0, 4'h2, 8'h00, lat, rd, werr, bcnt, pb);
        void'(model_step(0, 1'b0, 4'h2, 8'h00));
        checks++;
        if (rd !== model_dout[0] || lat !== 3) begin
            errors++;
            $display("FAIL reset_readback: dout=%h lat=%0d, required dout=%h lat=3", rd, lat, model_dout[0]);
        end
    endtask

    task automatic test_random();
        int lat, bcnt; logic [7:0] rd; logic werr, pb, ew;
        int k; logic w; logic [3:0] addr; logic [7:0] d;
        for (int n = 0; n < 20; n++) begin
            k = $urandom_range(0, 2);
            w = 1'($urandom_range(0, 1));
            addr = 4'($urandom_range(0, 15));
            d = 8'($urandom);
            run_access(k, w, addr, d, lat, rd, werr, bcnt, pb);
            ew = model_step(k, w, addr, d);
            checks++;
            if (lat !== ws_of[k] + 1 || rd !== model_dout[k] || werr !== ew || pb !== 1'b0) begin
                errors++;
                $display("FAIL random n=%0d k=%0d we=%b a=%h: lat=%0d dout=%h werr=%b post_busy=%b, required lat=%0d dout=%h werr=%b post_busy=0",
                         n, k, w, addr, lat, rd, werr, pb, ws_of[k] + 1, model_dout[k], ew);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            sel[k] = 1'b0; we[k] = 1'b0; a[k] = 4'h0; din[k] = 8'h00;
            model_dout[k] = 8'h00;
            for (int i = 0; i < 16; i++) model_mem[k][i] = 8'h12;
        end
        test_reset();
        test_vector_read();
        test_write();
        test_write_drop();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
